ascon_aead128_ctrl: RTL and testbench

Control FSM that sequences `data_path` through one Ascon-AEAD128 encryption: init, associated-data absorption, plaintext encryption and finalization/tag. It drives every `data_path` select and enable line and the round index. It also arbitrates the AD, plaintext, ciphertext and tag valid/ready handshakes with the surrounding core. Input blocks arrive already padded to 128 bits. Decryption is outside this block.

---
 rtl/ascon_aead128_ctrl.sv | 157 +++++++++++++++
 tb/tb_ascon_aead128_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_aead128_ctrl.sv
// Ascon-AEAD128 encryption sequencer: drives data_path selects/enables and round index, arbitrates AD/PT/CT/tag handshakes.
// Latency: 12 cycles start->first step, B_ROUNDS cycles per AD/data block, 12 cycles last step->tag.
// Backpressure: *_LAST and TAG states hold every output stable until their handshake fires; no output register.
module ascon_aead128_ctrl #(
  parameter int A_ROUNDS = 12,
  parameter int B_ROUNDS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       has_ad,
  input  logic       ad_valid,
  input  logic       ad_last,
  output logic       ad_ready,
  input  logic       db_valid,
  input  logic       db_last,
  output logic       db_ready,
  output logic       ct_valid,
  input  logic       ct_ready,
  output logic       tag_valid,
  input  logic       tag_ready,
  output logic       busy,
  output logic       done,
  output logic [3:0] rnd,
  output logic       en_internal,
  output logic       en_new_key,
  output logic       sel_state,
  output logic       sel_din,
  output logic       sel_dout,
  output logic       sel_xor_data,
  output logic [1:0] sel_xor_key,
  output logic       end_ad
);

  localparam logic [3:0] A_START = 4'(12 - A_ROUNDS);
  localparam logic [3:0] B_START = 4'(12 - B_ROUNDS);
  localparam logic [3:0] RND_LAST = 4'd11;

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_INIT_LAST, S_AD, S_AD_LAST,
    S_DATA, S_DATA_LAST, S_FINAL, S_TAG
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  logic       ad_pend_q, ad_pend_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rnd_q     <= 4'd0;
      ad_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rnd_q     <= rnd_d;
      ad_pend_q <= ad_pend_d;
    end
  end

  assign busy = (state_q != S_IDLE);

  always_comb begin
    state_d      = state_q;
    rnd_d        = rnd_q;
    ad_pend_d    = ad_pend_q;
    ad_ready     = 1'b0;
    db_ready     = 1'b0;
    ct_valid     = 1'b0;
    tag_valid    = 1'b0;
    done         = 1'b0;
    rnd          = 4'd0;
    en_internal  = 1'b0;
    en_new_key   = 1'b0;
    sel_state    = 1'b0;
    sel_din      = 1'b0;
    sel_dout     = 1'b0;
    sel_xor_data = 1'b0;
    sel_xor_key  = 2'b00;
    end_ad       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // rst gating keeps every output low while reset is asserted
        if (start && !rst) begin
          sel_state   = 1'b1;
          en_internal = 1'b1;
          en_new_key  = 1'b1;
          ad_pend_d   = has_ad;
          rnd_d       = A_START;
          state_d     = S_INIT;
        end
      end

      S_INIT, S_AD, S_DATA, S_FINAL: begin
        en_internal = 1'b1;
        rnd         = rnd_q;
        rnd_d       = rnd_q + 4'd1;
        if (rnd_q == 4'd10) begin
          unique case (state_q)
            S_INIT:  state_d = S_INIT_LAST;
            S_AD:    state_d = S_AD_LAST;
            S_DATA:  state_d = S_DATA_LAST;
            default: state_d = S_TAG;
          endcase
        end
      end

      S_INIT_LAST, S_AD_LAST, S_DATA_LAST: begin
        // final round of the permutation merged with the next block's absorption
        rnd            = RND_LAST;
        sel_xor_data   = 1'b1;
        sel_xor_key[0] = (state_q == S_INIT_LAST);
        if (ad_pend_q) begin
          sel_din     = 1'b0;
          ad_ready    = ad_valid;
          en_internal = ad_valid;
          if (ad_valid) begin
            if (ad_last) ad_pend_d = 1'b0;
            rnd_d   = B_START;
            state_d = S_AD;
          end
        end else begin
          sel_din        = 1'b1;
          db_ready       = ct_ready;
          ct_valid       = db_valid;
          sel_xor_key[1] = db_valid && db_last;
          end_ad         = (state_q != S_DATA_LAST);
          en_internal    = db_valid && ct_ready;
          if (db_valid && ct_ready) begin
            if (db_last) begin
              rnd_d   = A_START;
              state_d = S_FINAL;
            end else begin
              rnd_d   = B_START;
              state_d = S_DATA;
            end
          end
        end
      end

      S_TAG: begin
        tag_valid   = 1'b1;
        sel_dout    = 1'b1;
        sel_xor_key = 2'b01;
        rnd         = RND_LAST;
        if (tag_ready) begin
          done    = 1'b1;
          rnd_d   = 4'd0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ascon_aead128_ctrl.sv
// Bench for ascon_aead128_ctrl: directed latency scenarios plus randomized handshakes
// checked every cycle against a phase/countdown model of the encryption schedule.
module tb_ascon_aead128_ctrl;

  localparam int A = 12;
  localparam int B = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 0, has_ad = 0, ad_valid = 0, ad_last = 0;
  logic       db_valid = 0, db_last = 0, ct_ready = 0, tag_ready = 0;
  logic       ad_ready, db_ready, ct_valid, tag_valid, busy, done;
  logic [3:0] rnd;
  logic       en_internal, en_new_key, sel_state, sel_din, sel_dout, sel_xor_data, end_ad;
  logic [1:0] sel_xor_key;

  ascon_aead128_ctrl #(.A_ROUNDS(A), .B_ROUNDS(B)) dut (
    .clk(clk), .rst(rst), .start(start), .has_ad(has_ad),
    .ad_valid(ad_valid), .ad_last(ad_last), .ad_ready(ad_ready),
    .db_valid(db_valid), .db_last(db_last), .db_ready(db_ready),
    .ct_valid(ct_valid), .ct_ready(ct_ready),
    .tag_valid(tag_valid), .tag_ready(tag_ready),
    .busy(busy), .done(done), .rnd(rnd),
    .en_internal(en_internal), .en_new_key(en_new_key), .sel_state(sel_state),
    .sel_din(sel_din), .sel_dout(sel_dout), .sel_xor_data(sel_xor_data),
    .sel_xor_key(sel_xor_key), .end_ad(end_ad)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: 0 idle, 1 free-running rounds, 2 waiting for an AD/data step, 3 waiting for tag accept
  int m_mode = 0, m_round = 0, m_left = 0;
  bit m_ad_pend = 0, m_init = 0, m_first = 0, m_final = 0;
  int cyc = 0, t0 = 0;
  int ad_q[$], ct_q[$], done_q[$];
  bit last_ad_fire, last_db_fire;

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_ad_pend = 0; m_init = 0; m_first = 0; m_final = 0;
  endtask

  task automatic begin_rounds(input int first_rnd, input int cycles);
    m_mode = 1; m_round = first_rnd; m_left = cycles;
  endtask

  task automatic tick();
    logic [5:0] e_hs;
    logic [8:0] e_ctl;
    logic [3:0] e_rnd;
    logic e_ad_r, e_db_r, e_ct_v, e_tag_v, e_done, e_busy;
    logic e_en, e_nk, e_ss, e_din, e_dout, e_xd, e_ea;
    logic [1:0] e_xk;
    int rel;
    #1;
    {e_ad_r, e_db_r, e_ct_v, e_tag_v, e_done, e_busy} = '0;
    {e_en, e_nk, e_ss, e_din, e_dout, e_xd, e_ea} = '0;
    e_xk = 2'b00;
    e_rnd = 4'd0;
    case (m_mode)
      0: if (start) {e_en, e_nk, e_ss} = 3'b111;
      1: begin e_busy = 1; e_en = 1; e_rnd = 4'(m_round); end
      2: begin
        e_busy = 1; e_rnd = 4'd11; e_xd = 1; e_xk[0] = m_init;
        if (m_ad_pend) begin
          e_ad_r = ad_valid; e_en = ad_valid;
        end else begin
          e_din = 1; e_db_r = ct_ready; e_ct_v = db_valid;
          e_en = db_valid && ct_ready; e_xk[1] = db_valid && db_last; e_ea = m_first;
        end
      end
      default: begin
        e_busy = 1; e_tag_v = 1; e_dout = 1; e_xk = 2'b01; e_rnd = 4'd11; e_done = tag_ready;
      end
    endcase
    e_hs  = {e_busy, e_done, e_ad_r, e_db_r, e_ct_v, e_tag_v};
    e_ctl = {e_en, e_nk, e_ss, e_din, e_dout, e_xd, e_xk, e_ea};
    check("handshake", int'({busy, done, ad_ready, db_ready, ct_valid, tag_valid}), int'(e_hs));
    check("control", int'({en_internal, en_new_key, sel_state, sel_din, sel_dout,
                           sel_xor_data, sel_xor_key, end_ad}), int'(e_ctl));
    check("rnd", int'(rnd), int'(e_rnd));

    rel = cyc - t0;
    last_ad_fire = ad_ready && ad_valid;
    last_db_fire = db_ready && db_valid;
    if (last_ad_fire) ad_q.push_back(rel);
    if (ct_valid && ct_ready) ct_q.push_back(rel);
    if (done) done_q.push_back(rel);

    @(posedge clk);
    cyc++;
    case (m_mode)
      0: if (start) begin
        m_ad_pend = has_ad; m_init = 1; m_first = 1; m_final = 0; t0 = cyc - 1;
        begin_rounds(12 - A, A - 1);
      end
      1: begin
        m_round++; m_left--;
        if (m_left == 0) m_mode = m_final ? 3 : 2;
      end
      2: begin
        if (m_ad_pend) begin
          if (ad_valid) begin
            if (ad_last) m_ad_pend = 0;
            m_init = 0;
            begin_rounds(12 - B, B - 1);
          end
        end else if (db_valid && ct_ready) begin
          m_init = 0; m_first = 0;
          if (db_last) begin m_final = 1; begin_rounds(12 - A, A - 1); end
          else begin_rounds(12 - B, B - 1);
        end
      end
      default: if (tag_ready) m_mode = 0;
    endcase
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_handshake", int'({busy, done, ad_ready, db_ready, ct_valid, tag_valid}), 0);
    check("rst_control", int'({en_internal, en_new_key, sel_state, sel_din, sel_dout,
                               sel_xor_data, sel_xor_key, end_ad}), 0);
    check("rst_rnd", int'(rnd), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_msg(input int n_ad, input int n_db, input int stall, input int bp,
                         input bit guard);
    int ad_i = 0, db_i = 0;
    ad_q.delete(); ct_q.delete(); done_q.delete();
    {ad_valid, ad_last, db_valid, db_last} = '0;
    ct_ready = 1; tag_ready = 1;
    start = 1; has_ad = (n_ad > 0);
    tick();
    start = 0;
    for (int k = 1; k < 200 && done_q.size() == 0; k++) begin
      ad_valid = (ad_i < n_ad);
      ad_last  = (ad_i == n_ad - 1);
      db_valid = (ad_i == n_ad) && (db_i < n_db) && (k >= 12 + stall);
      db_last  = (db_i == n_db - 1);
      ct_ready = !(k >= 12 && k < 12 + bp);
      start    = guard && (k == 20);
      tick();
      if (last_ad_fire) ad_i++;
      if (last_db_fire) db_i++;
    end
    {start, ad_valid, db_valid} = '0;
    check("msg_completed", int'(done_q.size() != 0), 1);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", int'({busy, done, ad_ready, db_ready, ct_valid, tag_valid,
                                 en_internal, en_new_key, sel_state, rnd}), 0);
    rst = 1'b0;

    run_msg(0, 1, 0, 0, 0);
    check("min_ct_time", qat(ct_q, 0), 12);
    check("min_ct_count", ct_q.size(), 1);
    check("min_done_time", qat(done_q, 0), 24);
    tick();
    check("min_idle_after", int'(busy), 0);

    run_msg(2, 2, 0, 0, 0);
    check("ad0_time", qat(ad_q, 0), 12);
    check("ad1_time", qat(ad_q, 1), 20);
    check("ct0_time", qat(ct_q, 0), 28);
    check("ct1_time", qat(ct_q, 1), 36);
    check("ad2_done_time", qat(done_q, 0), 48);

    run_msg(0, 1, 5, 0, 0);
    check("stall_ct_time", qat(ct_q, 0), 17);
    check("stall_done_time", qat(done_q, 0), 29);

    run_msg(0, 1, 0, 3, 0);
    check("bp_ct_time", qat(ct_q, 0), 15);
    check("bp_done_time", qat(done_q, 0), 27);

    run_msg(0, 1, 0, 0, 1);
    check("guard_done_time", qat(done_q, 0), 24);
    for (int k = 0; k < 30; k++) tick();
    check("guard_done_count", done_q.size(), 1);

    // abort mid-AD, then a fresh message must run to completion normally
    ad_q.delete();
    start = 1; has_ad = 1; ct_ready = 1; tag_ready = 1;
    tick();
    start = 0; ad_valid = 1; ad_last = 0;
    for (int k = 1; k < 15; k++) tick();
    check("pre_reset_ad_seen", ad_q.size(), 1);
    do_reset();
    ad_valid = 0;
    run_msg(0, 1, 0, 0, 0);
    check("post_reset_ct_time", qat(ct_q, 0), 12);
    check("post_reset_done_time", qat(done_q, 0), 24);

    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(0, 7) == 0);
      has_ad    = $urandom_range(0, 1) == 1;
      ad_valid  = $urandom_range(0, 9) < 6;
      ad_last   = $urandom_range(0, 9) < 4;
      db_valid  = $urandom_range(0, 9) < 6;
      db_last   = $urandom_range(0, 9) < 3;
      ct_ready  = $urandom_range(0, 9) < 7;
      tag_ready = $urandom_range(0, 9) < 6;
      if ($urandom_range(0, 299) == 0) do_reset();
      else tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
